// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among N_REQ requesters.
// One operation in flight at a time: grant in IDLE, LAT cycles in EXEC, one-cycle result in RESP.
module add_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1
) (
    input  logic                   okClk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry,
    output logic [WIDTH-1:0]       last_sum,
    output logic [15:0]            op_count
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic             done;

    logic [N_REQ-1:0] rot;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;
    logic             gnt_any;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] id_q;
    logic [WIDTH:0]   sum_full;

    // Rotate req so bit 0 is the pointer position, then take the first set bit.
    always_comb begin
        rot     = N_REQ'({req, req} >> ptr);
        cand    = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                cand  = {1'b0, ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(N_REQ)) begin
                    cand = cand - (IDX_W+1)'(N_REQ);
                end
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        gnt_any = found && (state == S_IDLE) && !reset;
        gnt     = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
        ptr_nxt = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge okClk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, EXEC down-counter and registered response outputs.
    always_ff @(posedge okClk) begin
        if (reset) begin
            ptr       <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            last_sum  <= '0;
            op_count  <= '0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            rsp_valid <= done;
            if (gnt_any) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= gnt_idx;
                ptr  <= ptr_nxt;
                cnt  <= CNT_W'(LAT - 1);
            end else if ((state == S_EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (done) begin
                rsp_sum   <= sum_full[WIDTH-1:0];
                rsp_carry <= sum_full[WIDTH];
                rsp_id    <= id_q;
                last_sum  <= sum_full[WIDTH-1:0];
                op_count  <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: one LAT=1 instance and one LAT=3 instance.
module tb_add_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    localparam logic [3:0]  EXP_GNT [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [2:0]  EXP_ID  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    localparam logic [31:0] EXP_SUM [5] = '{32'd1001, 32'd2002, 32'd3003, 32'd4004, 32'd1001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst1, rst3;
    logic [N-1:0]   req1, req3;
    logic [N*W-1:0] a1, b1, a3, b3;
    logic [N-1:0]   gnt1, gnt3;
    logic           busy1, busy3, rv1, rv3, c1, c3;
    logic [2:0]     id1, id3;
    logic [W-1:0]   sum1, sum3, last1, last3;
    logic [15:0]    cnt1, cnt3;

    int checks = 0;
    int errors = 0;

    add_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(1)) dut1 (
        .okClk(clk), .reset(rst1), .req(req1), .a_in(a1), .b_in(b1),
        .gnt(gnt1), .busy(busy1), .rsp_valid(rv1), .rsp_id(id1),
        .rsp_sum(sum1), .rsp_carry(c1), .last_sum(last1), .op_count(cnt1)
    );

    add_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(3)) dut3 (
        .okClk(clk), .reset(rst3), .req(req3), .a_in(a3), .b_in(b3),
        .gnt(gnt3), .busy(busy3), .rsp_valid(rv3), .rsp_id(id3),
        .rsp_sum(sum3), .rsp_carry(c3), .last_sum(last3), .op_count(cnt3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until dut1 shows a result strobe, with a cycle bound.
    task automatic wait_rsp1;
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rv1 && n < 8);
        if (!rv1) check("rsp_wait", 64'(rv1), 64'(1));
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        req1 = 4'b1111; req3 = 4'b1111;
        a1 = '0; b1 = '0; a3 = '0; b3 = '0;

        // Reset state, gnt held off by reset even with all requests up
        tick(); tick(); #1;
        check("rst_gnt1", 64'(gnt1), 64'(0));
        check("rst_gnt3", 64'(gnt3), 64'(0));
        check("rst_busy", 64'(busy1), 64'(0));
        check("rst_rv", 64'(rv1), 64'(0));
        check("rst_id", 64'(id1), 64'(0));
        check("rst_sum", 64'(sum1), 64'(0));
        check("rst_carry", 64'(c1), 64'(0));
        check("rst_last", 64'(last1), 64'(0));
        check("rst_cnt", 64'(cnt1), 64'(0));

        // 5 + 7, LAT=1
        tick();
        rst1 = 1'b0; req1 = 4'b0001; a1[0*W +: W] = 32'd5; b1[0*W +: W] = 32'd7;
        #1;
        check("t1_gnt", 64'(gnt1), 64'(4'b0001));
        check("t1_busy_idle", 64'(busy1), 64'(0));
        tick();
        req1 = 4'b0000; a1[0*W +: W] = 32'd100;
        #1;
        check("t1_busy_exec", 64'(busy1), 64'(1));
        check("t1_gnt_exec", 64'(gnt1), 64'(0));
        check("t1_rv_exec", 64'(rv1), 64'(0));
        tick(); #1;
        check("t1_rv", 64'(rv1), 64'(1));
        check("t1_sum", 64'(sum1), 64'(12));
        check("t1_carry", 64'(c1), 64'(0));
        check("t1_id", 64'(id1), 64'(0));
        check("t1_last", 64'(last1), 64'(12));
        check("t1_cnt", 64'(cnt1), 64'(1));
        check("t1_busy_resp", 64'(busy1), 64'(1));
        tick(); #1;
        check("t1_rv_low", 64'(rv1), 64'(0));
        check("t1_busy_low", 64'(busy1), 64'(0));
        check("t1_sum_hold", 64'(sum1), 64'(12));

        // Single request at index 3 with pointer at 1; carry out
        tick();
        req1 = 4'b1000; a1[3*W +: W] = 32'hFFFF_FFFF; b1[3*W +: W] = 32'h0000_0002;
        #1;
        check("t2_gnt", 64'(gnt1), 64'(4'b1000));
        tick();
        req1 = 4'b0000;
        tick(); #1;
        check("t2_rv", 64'(rv1), 64'(1));
        check("t2_sum", 64'(sum1), 64'(1));
        check("t2_carry", 64'(c1), 64'(1));
        check("t2_id", 64'(id1), 64'(3));
        check("t2_last", 64'(last1), 64'(1));
        check("t2_cnt", 64'(cnt1), 64'(2));
        tick(); #1;
        check("t2_carry_hold", 64'(c1), 64'(1));

        // All requesters held: order 0,1,2,3,0 every 3 cycles
        tick();
        req1 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a1[i*W +: W] = 32'(1000 * (i + 1));
            b1[i*W +: W] = 32'(i + 1);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_gnt", 64'(gnt1), 64'(EXP_GNT[k]));
            tick(); #1;
            check("rr_gnt_exec", 64'(gnt1), 64'(0));
            tick(); #1;
            check("rr_rv", 64'(rv1), 64'(1));
            check("rr_id", 64'(id1), 64'(EXP_ID[k]));
            check("rr_sum", 64'(sum1), 64'(EXP_SUM[k]));
            tick();
        end
        req1 = 4'b0000;
        #1;
        check("rr_cnt", 64'(cnt1), 64'(7));

        // req[2] raised during EXEC is granted in the first IDLE cycle
        tick();
        req1 = 4'b0010;
        #1;
        check("late_first_gnt", 64'(gnt1), 64'(4'b0010));
        tick();
        req1 = 4'b0100;
        #1;
        check("late_exec_gnt", 64'(gnt1), 64'(0));
        tick(); #1;
        check("late_resp_rv", 64'(rv1), 64'(1));
        check("late_resp_id", 64'(id1), 64'(1));
        check("late_resp_gnt", 64'(gnt1), 64'(0));
        tick(); #1;
        check("late_gnt", 64'(gnt1), 64'(4'b0100));
        tick();
        req1 = 4'b0000;
        tick(); #1;
        check("late_rv", 64'(rv1), 64'(1));
        check("late_id", 64'(id1), 64'(2));
        check("late_sum", 64'(sum1), 64'(3003));
        check("late_cnt", 64'(cnt1), 64'(9));

        // Drive op_count to 0xFFFF, then one more wraps to zero
        tick();
        req1 = 4'b0001;
        for (int i = 0; i < 65526; i++) wait_rsp1();
        #1;
        check("wrap_ffff", 64'(cnt1), 64'(16'hFFFF));
        wait_rsp1();
        #1;
        check("wrap_zero", 64'(cnt1), 64'(0));
        check("wrap_sum", 64'(sum1), 64'(1001));
        req1 = 4'b0000;

        // LAT=3 instance: latency 4 cycles gnt -> rsp_valid
        tick();
        rst3 = 1'b0; req3 = 4'b0100;
        a3[2*W +: W] = 32'h1234_5678; b3[2*W +: W] = 32'h1111_1111;
        #1;
        check("l3_gnt", 64'(gnt3), 64'(4'b0100));
        tick();
        req3 = 4'b0000;
        #1;
        check("l3_busy", 64'(busy3), 64'(1));
        tick(); tick(); #1;
        check("l3_no_early", 64'(rv3), 64'(0));
        tick(); #1;
        check("l3_rv", 64'(rv3), 64'(1));
        check("l3_sum", 64'(sum3), 64'(32'h2345_6789));
        check("l3_carry", 64'(c3), 64'(0));
        check("l3_id", 64'(id3), 64'(2));
        check("l3_last", 64'(last3), 64'(32'h2345_6789));
        check("l3_cnt", 64'(cnt3), 64'(1));
        tick(); #1;
        check("l3_idle", 64'(busy3), 64'(0));

        // Reset two cycles after gnt aborts the operation and resets the pointer
        tick();
        req3 = 4'b0010; a3[1*W +: W] = 32'd10; b3[1*W +: W] = 32'd20;
        #1;
        check("ab_gnt", 64'(gnt3), 64'(4'b0010));
        tick();
        req3 = 4'b0000;
        tick();
        rst3 = 1'b1;
        #1;
        check("ab_busy_exec", 64'(busy3), 64'(1));
        tick();
        rst3 = 1'b0; req3 = 4'b0110;
        #1;
        check("ab_busy", 64'(busy3), 64'(0));
        check("ab_rv", 64'(rv3), 64'(0));
        check("ab_cnt", 64'(cnt3), 64'(0));
        check("ab_sum", 64'(sum3), 64'(0));
        check("ab_next_gnt", 64'(gnt3), 64'(4'b0010));
        tick();
        req3 = 4'b0000;
        #1;
        check("ab_no_rsp", 64'(rv3), 64'(0));
        tick(); tick(); tick(); #1;
        check("ab_new_rv", 64'(rv3), 64'(1));
        check("ab_new_id", 64'(id3), 64'(1));
        check("ab_new_sum", 64'(sum3), 64'(30));
        check("ab_new_cnt", 64'(cnt3), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing the adder (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the operand width, matching the wire endpoint width.
REQ-003 The block SHALL have parameter LAT, default 1, meaning the number of adder pipeline cycles (1..4).
REQ-004 The block SHALL have port okClk, input, 1 bit: the single clock, rising edge; all logic is synchronous to it.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester operation request, level.
REQ-007 The block SHALL have port a_in, input, N_REQ*WIDTH bits: operand A, requester i at [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port b_in, input, N_REQ*WIDTH bits: operand B, same packing as a_in.
REQ-009 The block SHALL have port gnt, output, N_REQ bits: one-hot, one-cycle acceptance pulse.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle result strobe.
REQ-012 The block SHALL have port rsp_id, output, 3 bits: index of the requester owning the result.
REQ-013 The block SHALL have port rsp_sum, output, WIDTH bits: the result, modulo 2^WIDTH.
REQ-014 The block SHALL have port rsp_carry, output, 1 bit: the carry out of the addition.
REQ-015 The block SHALL have port last_sum, output, WIDTH bits: the most recent rsp_sum, held for wire-out readback.
REQ-016 The block SHALL have port op_count, output, 16 bits: the number of completed operations.

Function
REQ-017 The FSM SHALL have the states IDLE, EXEC and RESP, and SHALL enter IDLE on reset.
REQ-018 In IDLE with any req bit high, the block SHALL assert gnt for exactly one requester in that cycle, capture its a/b operands and id on the same edge, and go to EXEC.
REQ-019 Arbitration SHALL be round-robin, with search starting at (last granted index + 1) mod N_REQ; after reset the search SHALL start at index 0.
REQ-020 gnt SHALL be combinational from req and the pointer, asserted only in IDLE, and never asserted for a requester whose req bit is low in that cycle.
REQ-021 Requesters SHALL hold req and operands stable until gnt; the requester may deassert req or change operands in the cycle after gnt without affecting the captured operation.
REQ-022 EXEC SHALL last exactly LAT cycles, counted by an internal down-counter, and SHALL then go to RESP.
REQ-023 The (WIDTH+1)-bit sum SHALL be formed from the captured operands, with bit WIDTH driving rsp_carry.
REQ-024 In RESP, rsp_valid SHALL be high for one cycle with rsp_sum, rsp_carry and rsp_id valid; the FSM SHALL then return to IDLE.
REQ-025 rsp_sum, rsp_carry and rsp_id SHALL hold their values outside RESP until the next RESP.
REQ-026 Latency from gnt to rsp_valid SHALL be LAT+1 cycles; the minimum issue interval SHALL be LAT+2 cycles.
REQ-027 busy SHALL be high in EXEC and RESP and low in IDLE.
REQ-028 last_sum SHALL update on the rsp_valid cycle to the rsp_sum value.
REQ-029 op_count SHALL increment by 1 per rsp_valid and SHALL wrap from 0xFFFF to 0x0000.
REQ-030 Requests arriving in EXEC or RESP SHALL not be granted until IDLE and SHALL not be lost if held.
REQ-031 When exactly one req bit is set, that requester SHALL be granted regardless of pointer position.

Reset
REQ-032 On reset, the block SHALL drive gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, last_sum=0, op_count=0, FSM=IDLE and pointer=0.
REQ-033 Reset asserted in EXEC or RESP SHALL abort the operation in the next cycle with no rsp_valid, and op_count SHALL be cleared.
REQ-034 Reset held high SHALL suppress gnt even when req bits are high.

Verification
REQ-035 The bench SHALL cover: LAT=1, req=0001, a0=5, b0=7 -> gnt=0001 at cycle t, rsp_valid at t+2 with rsp_sum=12, rsp_carry=0, rsp_id=0, and last_sum=12, op_count=1.
REQ-036 The bench SHALL cover: a=0xFFFFFFFF, b=0x00000002 -> rsp_sum=0x00000001, rsp_carry=1.
REQ-037 The bench SHALL cover: req=1111 held continuously -> grant order 0,1,2,3,0, each grant LAT+2 cycles apart, and rsp_id in the same order.
REQ-038 The bench SHALL cover: LAT=3, reset pulsed two cycles after gnt -> no rsp_valid, busy=0, op_count=0, and the next grant after reset goes to the lowest requesting index.
REQ-039 The bench SHALL cover: op_count preloaded via 65535 operations, then one more operation -> op_count=0x0000.
REQ-040 The bench SHALL cover: req[2] raised during EXEC and held -> gnt=0100 in the first IDLE cycle after RESP.
